// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding and the default operand width.
package serial_addsub_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_addsub_ctrl_fa_1bit.sv
// Single 1-bit full adder; the only arithmetic element of the serial datapath.
module FA_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through one full adder.
// Subtract is a + ~b + 1, so the carry register is seeded with sub_in.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic             sub_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out
);

  localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, sum_q, sum_d;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q;
  logic              carry_res_q;
  logic              ovf_q;
  logic              fa_sum, fa_cout;
  logic              last_bit;

  assign last_bit = (cnt_q == LastBit);

  FA_1bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_in) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy_out = (state_q == StRun) || (state_q == StDone);
    done_out = (state_q == StDone);
  end

  // New sum bit enters at the MSB while the register shifts right.
  always_comb begin
    sum_d            = sum_q >> 1;
    sum_d[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_res_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            a_q         <= a_in;
            b_q         <= sub_in ? ~b_in : b_in;
            carry_q     <= sub_in;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_res_q <= 1'b0;
            ovf_q       <= 1'b0;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CntW'(1);
          if (last_bit) begin
            // carry_q here is the carry into the MSB
            carry_res_q <= fa_cout;
            ovf_q       <= carry_q ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum_out      = sum_q;
  assign carry_out    = carry_res_q;
  assign overflow_out = ovf_q;

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start_in  input  1  request new operation; sampled only in IDLE.
REQ-005 sub_in  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start_in.
REQ-006 a_in  input  WIDTH  operand A, two's complement or unsigned; sampled with start_in.
REQ-007 b_in  input  WIDTH  operand B; sampled with start_in.
REQ-008 busy_out  output  1  high in RUN and DONE states.
REQ-009 done_out  output  1  one-cycle pulse; results valid in the same cycle.
REQ-010 sum_out  output  WIDTH  result; holds until the next accepted start_in.
REQ-011 carry_out  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-012 overflow_out  output  1  signed overflow of the completed operation.

Function
REQ-013 The block SHALL compute the operation bit-serially, one bit per clock, LSB first, through a single 1-bit full adder.
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE: start_in=1 SHALL load A into shift register A, B (or ~B if sub_in=1) into shift register B, load carry register with sub_in, clear bit counter, clear sum shift register, go to RUN.
REQ-016 RUN: each cycle the full adder SHALL take A[0], B[0] and the carry register; sum bit SHALL enter the sum shift register at the MSB while the register shifts right; A and B shift right; carry register updates; counter increments.
REQ-017 RUN SHALL exit to DONE on the cycle the counter equals WIDTH-1 (after processing that bit); WIDTH=1 SHALL give exactly one RUN cycle.
REQ-018 The carry register value entering the MSB bit SHALL be captured; overflow_out = captured MSB carry-in XOR final carry.
REQ-019 DONE: done_out=1 for exactly one cycle, then unconditional return to IDLE.
REQ-020 Latency: start_in sampled at edge k -> done_out high in the cycle after edge k+WIDTH (WIDTH+1 cycles total).
REQ-021 start_in in RUN or DONE SHALL be ignored without side effects; operand inputs need not be held after acceptance.
REQ-022 start_in in the IDLE cycle directly after DONE SHALL be accepted (back-to-back throughput one operation per WIDTH+2 cycles).
REQ-023 sum_out, carry_out, overflow_out SHALL remain stable from DONE until the next accepted start.
REQ-024 Results SHALL equal (A + B) mod 2^WIDTH for add and (A - B) mod 2^WIDTH for subtract, with carry per REQ-011.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE regardless of state, including mid-RUN; the partial operation is discarded.
REQ-026 Reset values: busy_out=0, done_out=0, sum_out=0, carry_out=0, overflow_out=0, counter=0, carry register=0.
REQ-027 start_in asserted in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-028 Package serial_addsub_pkg SHALL hold the FSM state encoding (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-029 The 1-bit full-adder SHALL be a separate instantiated sub-module, FA_1bit; no other adder logic in the datapath.
REQ-030 Counter width SHALL be clog2(WIDTH) bits minimum 1; no combinational path from inputs to outputs.

Verification (WIDTH=8)
REQ-031 add 0x5A+0x33 -> sum_out=0x8D, carry_out=0, overflow_out=1, done_out 9 cycles after start.
REQ-032 add 0xFF+0x01 -> sum_out=0x00, carry_out=1, overflow_out=0.
REQ-033 sub 0x10-0x20 -> sum_out=0xF0, carry_out=0, overflow_out=0; sub 0x80-0x01 -> sum_out=0x7F, carry_out=1, overflow_out=1.
REQ-034 start_in pulsed with new operands during RUN -> ignored; original result and single done_out pulse unchanged.
REQ-035 rst_n=0 on 4th RUN cycle -> next cycle IDLE, all outputs 0, no done_out; subsequent start completes normally.
REQ-036 start_in held high continuously with 0x01+0x01 -> done_out every 10 cycles, sum_out=0x02 each time.
